// File: rtl/cpu_mem_pkg.sv
// Shared types for the external data memory path: address/data widths,
// owner state encoding and the request record steered onto the memory port.
package cpu_mem_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 16;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ext_mem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the debug port asked for memory
// and was refused; at_limit forces the next debug slot.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/ext_mem_arbiter.sv
// Arbitrates the single-port external data memory between the CPU datapath
// and the debug/loader port: CPU priority, starvation guard, debug burst lock.
module ext_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW           = MEM_AW,
  parameter int DW           = MEM_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  owner_e   r_owner;
  owner_e   w_owner_nxt;
  logic     w_cpu_gnt;
  logic     w_dbg_gnt;
  logic     w_at_limit;
  mem_req_t w_cpu_req;
  mem_req_t w_dbg_req;
  mem_req_t w_sel;

  logic          r_cpu_rvalid;
  logic          r_dbg_rvalid;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dbg_rdata;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_dbg_gnt | ~dbg_req),
    .i_inc      (dbg_req & ~w_dbg_gnt),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_CPU;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // A locked owner that drops dbg_lock is arbitrated as OWN_CPU in that cycle.
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dbg_gnt   = 1'b0;
    w_owner_nxt = r_owner;
    if (!rst) begin
      if ((r_owner == OWN_DBG) && dbg_lock) begin
        w_dbg_gnt   = dbg_req;
        w_owner_nxt = OWN_DBG;
      end else begin
        w_dbg_gnt   = dbg_req & (~cpu_req | w_at_limit);
        w_cpu_gnt   = cpu_req & ~w_dbg_gnt;
        w_owner_nxt = (w_dbg_gnt && dbg_lock) ? OWN_DBG : OWN_CPU;
      end
    end
  end

  assign w_cpu_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign w_dbg_req = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  assign w_sel     = w_dbg_gnt ? w_dbg_req : w_cpu_req;

  assign mem_en    = w_cpu_gnt | w_dbg_gnt;
  assign mem_we    = mem_en & w_sel.we;
  assign mem_addr  = w_sel.addr;
  assign mem_wdata = w_sel.wdata;

  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
      if (w_cpu_gnt && !cpu_we) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (w_dbg_gnt && !dbg_we) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: reset-mid-read sequence, then a
// per-cycle vector table with a behavioural 256x16 memory behind the port.
module tb_ext_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [7:0]  cpu_addr, dbg_addr, mem_addr;
  logic [15:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [15:0] cpu_rdata, dbg_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_mem_arbiter #(.AW(8), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural memory; known contents are reloaded while rst is high.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 16'h0000;
      mem[1] <= 16'h0012;
      mem[2] <= 16'h2222;
      mem[3] <= 16'h3333;
      mem[5] <= 16'h0000;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        cr, cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        dr, dw;
    logic [7:0]  da;
    logic [15:0] dd;
    logic        dl;
    logic        e_cg, e_dg, e_st, e_en, e_we;
    logic [7:0]  e_addr;
    logic        e_crv;
    logic [15:0] e_crd;
    logic        e_drv;
    logic [15:0] e_drd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic cr, logic cw, logic [7:0] ca, logic [15:0] cd,
    logic dr, logic dw, logic [7:0] da, logic [15:0] dd, logic dl,
    logic cg, logic dg, logic st, logic en, logic we, logic [7:0] addr,
    logic crv, logic [15:0] crd, logic drv, logic [15:0] drd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.dl = dl;
    v.e_cg = cg; v.e_dg = dg; v.e_st = st; v.e_en = en; v.e_we = we; v.e_addr = addr;
    v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;

    // Contention sequence: dbg forced on c5 and c10; c15 is the forced slot
    // that opens the locked burst.
    tbl.push_back(mk(1,1,8'h05,16'h00AB, 0,0,8'h00,16'h0,0, 1,0,0,1,1,8'h05, 0,16'h0000,0,16'h0000));
    tbl.push_back(mk(1,0,8'h05,16'h0,    0,0,8'h00,16'h0,0, 1,0,0,1,0,8'h05, 0,16'h0000,0,16'h0000));
    tbl.push_back(mk(0,0,8'h05,16'h0,    0,0,8'h00,16'h0,0, 0,0,0,0,0,8'h05, 1,16'h00AB,0,16'h0000));
    tbl.push_back(mk(1,0,8'h02,16'h0,    0,0,8'h00,16'h0,0, 1,0,0,1,0,8'h02, 0,16'h00AB,0,16'h0000));
    tbl.push_back(mk(0,0,8'h02,16'h0,    1,0,8'h03,16'h0,0, 0,1,0,1,0,8'h03, 1,16'h2222,0,16'h0000));
    tbl.push_back(mk(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,0, 0,0,0,0,0,8'h00, 0,16'h2222,1,16'h3333));
    tbl.push_back(mk(1,0,8'h05,16'h0,    1,0,8'h01,16'h0,0, 1,0,0,1,0,8'h05, 0,16'h2222,0,16'h3333));
    for (int k = 2; k <= 4; k++)
      tbl.push_back(mk(1,0,8'h05,16'h0,  1,0,8'h01,16'h0,0, 1,0,0,1,0,8'h05, 1,16'h00AB,0,16'h3333));
    tbl.push_back(mk(1,0,8'h05,16'h0,    1,0,8'h01,16'h0,0, 0,1,1,1,0,8'h01, 1,16'h00AB,0,16'h3333));
    tbl.push_back(mk(1,0,8'h05,16'h0,    1,0,8'h01,16'h0,0, 1,0,0,1,0,8'h05, 0,16'h00AB,1,16'h0012));
    for (int k = 7; k <= 9; k++)
      tbl.push_back(mk(1,0,8'h05,16'h0,  1,0,8'h01,16'h0,0, 1,0,0,1,0,8'h05, 1,16'h00AB,0,16'h0012));
    tbl.push_back(mk(1,0,8'h05,16'h0,    1,0,8'h01,16'h0,0, 0,1,1,1,0,8'h01, 1,16'h00AB,0,16'h0012));
    tbl.push_back(mk(1,0,8'h05,16'h0,    1,0,8'h01,16'h0,0, 1,0,0,1,0,8'h05, 0,16'h00AB,1,16'h0012));
    for (int k = 12; k <= 14; k++)
      tbl.push_back(mk(1,0,8'h05,16'h0,  1,0,8'h01,16'h0,0, 1,0,0,1,0,8'h05, 1,16'h00AB,0,16'h0012));
    // Locked burst, CPU still requesting.
    tbl.push_back(mk(1,0,8'h05,16'h0,    1,1,8'h00,16'h0010,1, 0,1,1,1,1,8'h00, 1,16'h00AB,0,16'h0012));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1,0,8'h05,16'h0,  1,1,8'(k),16'(16'h0010 + k),1, 0,1,1,1,1,8'(k), 0,16'h00AB,0,16'h0012));
    // Lock held with no debug request: no access, CPU stalled.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,8'h00,16'h0,  0,0,8'h00,16'h0,1, 0,0,1,0,0,8'h00, 0,16'h00AB,0,16'h0012));
    // Lock released: CPU granted same cycle, then readback of the burst.
    tbl.push_back(mk(1,0,8'h00,16'h0,    0,0,8'h00,16'h0,0, 1,0,0,1,0,8'h00, 0,16'h00AB,0,16'h0012));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(1,0,8'(k),16'h0,  0,0,8'h00,16'h0,0, 1,0,0,1,0,8'(k), 1,16'(16'h000F + k),0,16'h0012));
    tbl.push_back(mk(0,0,8'h03,16'h0,    0,0,8'h00,16'h0,0, 0,0,0,0,0,8'h03, 1,16'h0013,0,16'h0012));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset arriving while a read is in flight must drop the response.
    @(posedge clk);
    #1 cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    @(negedge clk);
    chk("rst_pre_gnt", 32'(cpu_gnt), 32'd1);
    chk("rst_pre_rdata_bus", 32'(mem_rdata), 32'h0012);
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    @(negedge clk);
    cpu_req = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rel_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_rel_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      dbg_req = tbl[i].dr; dbg_we = tbl[i].dw; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dd;
      dbg_lock = tbl[i].dl;
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i),    32'(cpu_gnt),    32'(tbl[i].e_cg));
      chk($sformatf("v%0d_dbg_gnt", i),    32'(dbg_gnt),    32'(tbl[i].e_dg));
      chk($sformatf("v%0d_cpu_stall", i),  32'(cpu_stall),  32'(tbl[i].e_st));
      chk($sformatf("v%0d_mem_en", i),     32'(mem_en),     32'(tbl[i].e_en));
      chk($sformatf("v%0d_mem_we", i),     32'(mem_we),     32'(tbl[i].e_we));
      chk($sformatf("v%0d_mem_addr", i),   32'(mem_addr),   32'(tbl[i].e_addr));
      chk($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].e_crv));
      chk($sformatf("v%0d_cpu_rdata", i),  32'(cpu_rdata),  32'(tbl[i].e_crd));
      chk($sformatf("v%0d_dbg_rvalid", i), 32'(dbg_rvalid), 32'(tbl[i].e_drv));
      chk($sformatf("v%0d_dbg_rdata", i),  32'(dbg_rdata),  32'(tbl[i].e_drd));
      if (tbl[i].e_dg && tbl[i].e_we)
        chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].dd));
      chk($sformatf("v%0d_both_rvalid", i), 32'(cpu_rvalid & dbg_rvalid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
